// File: rtl/bsg_serializer.sv
// Frame serializer: loads {bsg_data_1, bsg_data_0} on an EN rising edge and shifts it
// out one bit per (DIV+1) cycles, MSB- or LSB-first, with optional back-to-back looping.
module bsg_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                SYS_CLK,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               bsg_control,
    input  logic [DATA_WIDTH-1:0]               bsg_data_0,
    input  logic [DATA_WIDTH-1:0]               bsg_data_1,
    output logic                                bit_out,
    output logic                                bit_strobe,
    output logic [$clog2(2*DATA_WIDTH)-1:0]     bit_idx,
    output logic                                busy,
    output logic                                done
);

    localparam int F     = 2 * DATA_WIDTH;
    localparam int IDX_W = $clog2(F);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_en_q;
    logic [F-1:0]     r_shreg;
    logic [3:0]       r_div;
    logic [3:0]       r_cnt;
    logic             r_msb;
    logic             r_bit_out;
    logic             r_strobe;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;

    logic             w_en;
    logic             w_loop;
    logic             w_msb;
    logic [3:0]       w_div;
    logic [F-1:0]     w_load_word;
    logic             w_start;
    logic             w_last_cnt;
    logic             w_last_bit;
    logic             w_unused_ctrl;

    assign w_en          = bsg_control[0];
    assign w_loop        = bsg_control[1];
    assign w_msb         = bsg_control[2];
    assign w_div         = bsg_control[7:4];
    assign w_unused_ctrl = ^bsg_control;
    assign w_load_word   = {bsg_data_1, bsg_data_0};
    assign w_start       = w_en & ~r_en_q;
    assign w_last_cnt    = (r_cnt == r_div);
    assign w_last_bit    = (r_idx == IDX_W'(F - 1));

    always_ff @(posedge SYS_CLK) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_en_q    <= 1'b0;
            r_shreg   <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_msb     <= 1'b0;
            r_bit_out <= 1'b0;
            r_strobe  <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_en_q <= w_en;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!w_en) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_bit_out <= 1'b0;
                        r_strobe  <= 1'b0;
                        r_idx     <= '0;
                    end else begin
                        // First bit is presented straight from the inputs so it appears the cycle after LOAD.
                        r_shreg   <= w_load_word;
                        r_div     <= w_div;
                        r_msb     <= w_msb;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_bit_out <= w_msb ? w_load_word[F-1] : w_load_word[0];
                        r_strobe  <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!w_en) begin
                        // Abort wins over frame completion: no done pulse.
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_bit_out <= 1'b0;
                        r_strobe  <= 1'b0;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                    end else if (!w_last_cnt) begin
                        r_cnt    <= r_cnt + 4'd1;
                        r_strobe <= 1'b0;
                    end else if (!w_last_bit) begin
                        r_cnt     <= '0;
                        r_idx     <= r_idx + 1'b1;
                        r_strobe  <= 1'b1;
                        r_shreg   <= r_msb ? (r_shreg << 1) : (r_shreg >> 1);
                        r_bit_out <= r_msb ? r_shreg[F-2] : r_shreg[1];
                    end else if (w_loop) begin
                        r_state   <= S_LOAD;
                        r_bit_out <= 1'b0;
                        r_strobe  <= 1'b0;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bit_out <= 1'b0;
                        r_strobe  <= 1'b0;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bit_out    = r_bit_out;
    assign bit_strobe = r_strobe;
    assign bit_idx    = r_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_bsg_serializer.sv
// Directed bench for bsg_serializer: expected bit streams are queued at frame start
// and popped cycle by cycle as the serializer emits them.
module tb_bsg_serializer;

    logic       SYS_CLK = 1'b0;
    logic       rst;
    logic [7:0] bsg_control;
    logic [7:0] bsg_data_0;
    logic [7:0] bsg_data_1;
    logic       bit_out;
    logic       bit_strobe;
    logic [3:0] bit_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    bit exp_q[$];

    bsg_serializer #(.DATA_WIDTH(8)) dut (
        .SYS_CLK    (SYS_CLK),
        .rst        (rst),
        .bsg_control(bsg_control),
        .bsg_data_0 (bsg_data_0),
        .bsg_data_1 (bsg_data_1),
        .bit_out    (bit_out),
        .bit_strobe (bit_strobe),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic push_frame(input bit msb);
        logic [15:0] w;
        w = {bsg_data_1, bsg_data_0};
        for (int i = 0; i < 16; i++)
            exp_q.push_back(msb ? w[15-i] : w[i]);
    endtask

    task automatic pop_exp(output bit e);
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'(exp_q.size()), 32'd1);
            e = 1'b0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Checks nbits bit periods starting at the first cycle of bit 0.
    task automatic check_bits(input int div, input int nbits, input int chg_at, input logic [7:0] chg_val);
        bit e;
        for (int b = 0; b < nbits; b++) begin
            pop_exp(e);
            for (int k = 0; k <= div; k++) begin
                chk("bit_out", 32'(bit_out), 32'(e));
                chk("bit_strobe", 32'(bit_strobe), 32'(k == 0));
                chk("bit_idx", 32'(bit_idx), 32'(b));
                chk("busy_shift", 32'(busy), 32'd1);
                chk("done_shift", 32'(done), 32'd0);
                if (b == chg_at && k == 0)
                    bsg_data_0 = chg_val;
                step();
            end
        end
    endtask

    // Raise EN via ctrl from IDLE, check the LOAD cycle, then check nbits.
    task automatic run_frame(input logic [7:0] ctrl, input int nbits, input int chg_at, input logic [7:0] chg_val);
        bsg_control = ctrl;
        step();
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_strobe", 32'(bit_strobe), 32'd0);
        chk("load_bit_out", 32'(bit_out), 32'd0);
        chk("load_done", 32'(done), 32'd0);
        push_frame(ctrl[2]);
        step();
        check_bits(int'(ctrl[7:4]), nbits, chg_at, chg_val);
    endtask

    task automatic check_done();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_bit_out", 32'(bit_out), 32'd0);
        chk("done_strobe", 32'(bit_strobe), 32'd0);
        step();
        chk("done_clear", 32'(done), 32'd0);
        frames++;
        $display("frame %0d complete at %0t", frames, $time);
    endtask

    initial begin
        bit e;
        rst         = 1'b0;
        bsg_control = 8'h00;
        bsg_data_1  = 8'hA5;
        bsg_data_0  = 8'h3C;
        step();
        step();
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        chk("rst_strobe", 32'(bit_strobe), 32'd0);
        chk("rst_idx", 32'(bit_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        step();

        // MSB first, DIV=0
        run_frame(8'h05, 16, -1, 8'h00);
        check_done();

        // EN held high after a non-loop frame must not restart
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_en_busy", 32'(busy), 32'd0);
            chk("hold_en_done", 32'(done), 32'd0);
        end
        bsg_control = 8'h00;
        step();

        // LSB first after a fresh EN edge
        run_frame(8'h01, 16, -1, 8'h00);
        check_done();
        bsg_control = 8'h00;
        step();

        // DIV=3: each bit held four cycles
        run_frame(8'h35, 16, -1, 8'h00);
        check_done();
        bsg_control = 8'h00;
        step();

        // Loop mode with data change mid-frame
        run_frame(8'h07, 16, 4, 8'hFF);
        chk("loop_load_busy", 32'(busy), 32'd1);
        chk("loop_load_done", 32'(done), 32'd0);
        chk("loop_load_strobe", 32'(bit_strobe), 32'd0);
        chk("loop_load_bit_out", 32'(bit_out), 32'd0);
        push_frame(1'b1);
        step();
        check_bits(0, 15, -1, 8'h00);
        // Drop EN on the final bit: abort must beat frame completion
        pop_exp(e);
        chk("last_bit_out", 32'(bit_out), 32'(e));
        chk("last_bit_idx", 32'(bit_idx), 32'd15);
        bsg_control = 8'h06;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bit_out", 32'(bit_out), 32'd0);
        chk("abort_strobe", 32'(bit_strobe), 32'd0);
        chk("abort_idx", 32'(bit_idx), 32'd0);
        step();
        chk("abort_done_after", 32'(done), 32'd0);
        chk("abort_busy_after", 32'(busy), 32'd0);
        $display("loop frames aborted at %0t", $time);
        bsg_data_0  = 8'h3C;
        bsg_control = 8'h00;
        step();

        // Reset mid-frame at bit 7, EN still high at release
        run_frame(8'h05, 7, -1, 8'h00);
        chk("pre_rst_idx", 32'(bit_idx), 32'd7);
        rst = 1'b0;
        step();
        chk("midrst_bit_out", 32'(bit_out), 32'd0);
        chk("midrst_strobe", 32'(bit_strobe), 32'd0);
        chk("midrst_idx", 32'(bit_idx), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        rst = 1'b1;
        step();
        chk("restart_load_busy", 32'(busy), 32'd1);
        push_frame(1'b1);
        step();
        check_bits(0, 16, -1, 8'h00);
        check_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
